// File: rtl/trdb_resync_ctrl.sv
// Resync controller: turns trdb_resync_counter max flags into sync-packet requests,
// escalating to a forced sync on timeout. Optional stats outputs: TRDB_RESYNC_STATS_EN.
module trdb_resync_ctrl #(
  parameter int unsigned MAX_WAIT    = 16,
  parameter logic [1:0]  SYNC_FORMAT = 2'b11
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       trace_enabled_i,
  input  logic       et_resync_max_i,
  input  logic       gt_resync_max_i,
  input  logic       pkt_valid_i,
  input  logic       pkt_ready_i,
  input  logic [1:0] pkt_format_i,
  output logic       resync_req_o,
  output logic       force_sync_o,
  output logic       packet_emitted_o,
  output logic       resync_rst_o
`ifdef TRDB_RESYNC_STATS_EN
  ,
  output logic [15:0] sync_count_o,
  output logic [15:0] forced_count_o
`endif
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  typedef enum logic [1:0] {IDLE, PENDING, FORCE} state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            hs, sync_hs;

  always_comb begin
    hs      = pkt_valid_i & pkt_ready_i;
    sync_hs = hs & (pkt_format_i == SYNC_FORMAT);
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (!trace_enabled_i) begin
      state_d = IDLE;
      wait_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((et_resync_max_i | gt_resync_max_i) & ~sync_hs)
            state_d = gt_resync_max_i ? FORCE : PENDING;
        end
        PENDING: begin
          if (wait_q != WAIT_MAX) wait_d = wait_q + WAIT_ONE;
          // a sync arriving on the timeout cycle still returns to IDLE
          if (sync_hs) begin
            state_d = IDLE;
            wait_d  = '0;
          end else if (gt_resync_max_i || (wait_q == WAIT_LAST)) begin
            state_d = FORCE;
          end
        end
        FORCE: begin
          if (sync_hs) begin
            state_d = IDLE;
            wait_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          wait_d  = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they land one cycle after the inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      wait_q           <= '0;
      resync_req_o     <= 1'b0;
      force_sync_o     <= 1'b0;
      packet_emitted_o <= 1'b0;
      resync_rst_o     <= 1'b0;
    end else begin
      state_q          <= state_d;
      wait_q           <= wait_d;
      resync_req_o     <= (state_d != IDLE);
      force_sync_o     <= (state_d == FORCE);
      packet_emitted_o <= hs;
      resync_rst_o     <= sync_hs;
    end
  end

`ifdef TRDB_RESYNC_STATS_EN
  logic sync_exit, forced_exit;

  always_comb begin
    sync_exit   = trace_enabled_i & sync_hs & (state_q != IDLE);
    forced_exit = trace_enabled_i & sync_hs & (state_q == FORCE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_count_o   <= '0;
      forced_count_o <= '0;
    end else begin
      if (sync_exit && (sync_count_o != '1))     sync_count_o   <= sync_count_o + 16'd1;
      if (forced_exit && (forced_count_o != '1)) forced_count_o <= forced_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trdb_resync_ctrl.sv
// Bench for trdb_resync_ctrl: request-age model checked every cycle plus literal spot checks.
module tb_trdb_resync_ctrl;

  localparam int unsigned MW = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       trace_enabled_i, et_resync_max_i, gt_resync_max_i;
  logic       pkt_valid_i, pkt_ready_i;
  logic [1:0] pkt_format_i;
  logic       resync_req_o, force_sync_o, packet_emitted_o, resync_rst_o;
`ifdef TRDB_RESYNC_STATS_EN
  logic [15:0] sync_count_o, forced_count_o;
`endif

  always #5 clk_i = ~clk_i;

  trdb_resync_ctrl #(.MAX_WAIT(MW), .SYNC_FORMAT(2'b11)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .trace_enabled_i  (trace_enabled_i),
    .et_resync_max_i  (et_resync_max_i),
    .gt_resync_max_i  (gt_resync_max_i),
    .pkt_valid_i      (pkt_valid_i),
    .pkt_ready_i      (pkt_ready_i),
    .pkt_format_i     (pkt_format_i),
    .resync_req_o     (resync_req_o),
    .force_sync_o     (force_sync_o),
    .packet_emitted_o (packet_emitted_o),
    .resync_rst_o     (resync_rst_o)
`ifdef TRDB_RESYNC_STATS_EN
    ,
    .sync_count_o     (sync_count_o),
    .forced_count_o   (forced_count_o)
`endif
  );

  int checks = 0;
  int passes = 0;

  // Model: a request is outstanding from the flag until a sync is taken;
  // it becomes mandatory once it has aged MW cycles or gt was seen.
  logic m_out, m_force, m_pe, m_rr;
  int   m_age;

  always @(posedge clk_i or negedge rst_ni) begin
    logic h, s, n_out, n_force;
    int   n_age;
    if (!rst_ni) begin
      m_out <= 1'b0; m_force <= 1'b0; m_pe <= 1'b0; m_rr <= 1'b0; m_age <= 0;
    end else begin
      h = pkt_valid_i && pkt_ready_i;
      s = h && (pkt_format_i == 2'b11);
      n_out = m_out; n_force = m_force; n_age = m_age;
      if (!trace_enabled_i) begin
        n_out = 1'b0; n_force = 1'b0; n_age = 0;
      end else if (m_out) begin
        if (s) begin
          n_out = 1'b0; n_force = 1'b0; n_age = 0;
        end else begin
          n_age = m_age + 1;
          if (gt_resync_max_i || n_age >= int'(MW)) n_force = 1'b1;
        end
      end else if ((et_resync_max_i || gt_resync_max_i) && !s) begin
        n_out = 1'b1; n_age = 0; n_force = gt_resync_max_i;
      end
      m_out <= n_out; m_force <= n_force; m_age <= n_age;
      m_pe <= h; m_rr <= s;
    end
  end

  always @(negedge clk_i) begin
    checks++;
    if ({resync_req_o, force_sync_o, packet_emitted_o, resync_rst_o} ===
        {m_out, m_force, m_pe, m_rr})
      passes++;
    else
      $display("FAIL model t=%0t req/force/pe/rr got %b%b%b%b expected %b%b%b%b", $time,
               resync_req_o, force_sync_o, packet_emitted_o, resync_rst_o,
               m_out, m_force, m_pe, m_rr);
  end

  task automatic chk(input string name, input logic [3:0] exp);
    checks++;
    if ({resync_req_o, force_sync_o, packet_emitted_o, resync_rst_o} === exp)
      passes++;
    else
      $display("FAIL %s req/force/pe/rr got %b%b%b%b expected %b", name,
               resync_req_o, force_sync_o, packet_emitted_o, resync_rst_o, exp);
  endtask

  task automatic tick(input logic en, input logic et, input logic gt,
                      input logic v, input logic r, input logic [1:0] f);
    trace_enabled_i = en; et_resync_max_i = et; gt_resync_max_i = gt;
    pkt_valid_i = v; pkt_ready_i = r; pkt_format_i = f;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    trace_enabled_i = 1'b1; et_resync_max_i = 1'b0; gt_resync_max_i = 1'b0;
    pkt_valid_i = 1'b0; pkt_ready_i = 1'b0; pkt_format_i = 2'b00;
    tick(1, 1, 0, 1, 1, 3);
    tick(1, 1, 0, 1, 1, 3);
    chk("in_reset", 4'b0000);
    rst_ni = 1'b1;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("idle_after_reset", 4'b0000);

    // normal resync; sync lands on the would-be timeout cycle
    tick(1, 1, 0, 0, 0, 0);
    chk("pending_entry", 4'b1000);
    repeat (3) tick(1, 1, 0, 0, 0, 0);
    chk("pending_age3", 4'b1000);
    tick(1, 1, 0, 1, 1, 3);
    chk("sync_served", 4'b0011);
    tick(1, 0, 0, 0, 0, 0);
    chk("idle_after_sync", 4'b0000);

    // timeout escalation
    tick(1, 1, 0, 0, 0, 0);
    chk("to_pending", 4'b1000);
    repeat (3) tick(1, 1, 0, 0, 0, 0);
    chk("before_timeout", 4'b1000);
    tick(1, 1, 0, 0, 0, 0);
    chk("timeout_force", 4'b1100);
    tick(1, 1, 0, 1, 0, 3);
    chk("no_ready_no_pulse", 4'b1100);

    // non-sync packets do not leave FORCE
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 1, 1, 1);
      chk("nonsync_pulse", 4'b1110);
      tick(1, 1, 0, 0, 0, 0);
      chk("nonsync_gap", 4'b1100);
    end
    tick(1, 1, 0, 1, 1, 3);
    chk("force_sync_exit", 4'b0011);
    tick(1, 0, 0, 0, 0, 0);

    // gt from IDLE, then disable
    tick(1, 0, 1, 0, 0, 0);
    chk("gt_direct", 4'b1100);
    tick(0, 0, 1, 0, 0, 0);
    chk("disable_drop", 4'b0000);
    tick(0, 0, 0, 1, 1, 3);
    chk("disabled_pulses", 4'b0011);

    // gt while pending
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 0);
    chk("gt_in_pending", 4'b1100);
    tick(1, 0, 0, 1, 1, 3);
    tick(1, 0, 0, 0, 0, 0);

    // flag and sync in the same IDLE cycle
    tick(1, 1, 0, 1, 1, 3);
    chk("simul_idle", 4'b0011);
    tick(1, 0, 0, 0, 0, 0);
    chk("simul_after", 4'b0000);

    // asynchronous reset mid-PENDING
    tick(1, 1, 0, 0, 0, 0);
    chk("pre_reset_pending", 4'b1000);
    #2 rst_ni = 1'b0;
    #1 chk("async_reset", 4'b0000);
    tick(1, 0, 0, 0, 0, 0);
    rst_ni = 1'b1;
    tick(1, 0, 0, 0, 0, 0);
    chk("post_reset_idle", 4'b0000);

    tick(1, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
